spi_flash_xip_slave: RTL and testbench

- Synthesizable SPI NOR-flash responder; sits directly downstream of the APB SPI master, on its spi_sck/spi_ss/spi_mosi/spi_miso pins.
- Serves the master's XIP read sequence (cmd 0x03 + 24-bit address, data shifted out) from a word-wide backing memory port.
- Oversamples the SPI pins with the system clock: all logic is in one clock domain, and there is no sck-clocked logic.

---
 rtl/spi_flash_xip_slave_if.sv | 24 ++
 rtl/spi_flash_xip_slave.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_flash_xip_slave.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_xip_slave_if.sv
// SPI pin and backing-memory port bundle for the XIP flash responder.
// slave: the flash responder view; master: the SPI master / memory side.
interface spi_flash_xip_slave_if #(
    parameter int unsigned ADDR_BITS = 24
);
    logic                   spi_sck;
    logic                   spi_ss;
    logic                   spi_mosi;
    logic                   spi_miso;
    logic                   spi_miso_oe;
    logic                   mem_rd;
    logic [ADDR_BITS-3:0]   mem_addr;
    logic [31:0]            mem_rdata;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_rd, mem_addr
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_rd, mem_addr
    );
endinterface

// File: rtl/spi_flash_xip_slave.sv
// SPI NOR-flash XIP read responder (cmd 0x03 + 24-bit address, data out).
// SPI pins are oversampled by the system clock; no sck-clocked logic.
// Optional: define SPI_FLASH_FAST_READ_EN to also accept 0x0B with 8 dummy clocks.
module spi_flash_xip_slave #(
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          SS_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_flash_xip_slave_if.slave  bus,
    output logic                  busy
);
    localparam int unsigned WADDR_BITS = ADDR_BITS - 2;
    localparam int unsigned CNT_BITS   = 5;
    localparam int unsigned SHIFT_BITS = 23;
    localparam logic        SS_IDLE    = SS_ACTIVE_LOW;
    localparam logic [7:0]  CMD_READ   = 8'h03;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d, ss_act_d;
    logic                   sck_s, mosi_s, ss_act, rise, fall, sel_edge;

    state_t                 state_q, state_n;
    logic [CNT_BITS-1:0]    bit_cnt_q, bit_cnt_n;
    logic [2:0]             bit_idx_q, bit_idx_n;
    logic [SHIFT_BITS-1:0]  shift_q, shift_n;
    logic [ADDR_BITS-1:0]   addr_q, addr_n;
    logic [31:0]            word_buf_q, word_buf_n;
    logic                   cap_q, cap_n;
    logic                   first_q, first_n;
    logic                   miso_q, miso_n;
    logic                   oe_q, oe_n;
    logic                   mem_rd_q, mem_rd_n;
    logic [WADDR_BITS-1:0]  mem_addr_q, mem_addr_n;
    logic                   busy_n;
`ifdef SPI_FLASH_FAST_READ_EN
    logic                   fast_q, fast_n;
`endif

    logic [7:0]             cmd_in;
    logic [23:0]            addr_full;
    logic [ADDR_BITS-1:0]   addr_in, addr_inc;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_act    = SS_ACTIVE_LOW ? ~ss_sync[SYNC_STAGES-1] : ss_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign sel_edge  = ss_act & ~ss_act_d;
    assign cmd_in    = {shift_q[6:0], mosi_s};
    assign addr_full = {shift_q, mosi_s};
    assign addr_in   = addr_full[ADDR_BITS-1:0];
    assign addr_inc  = addr_q + ADDR_BITS'(1);

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;

    // Pin synchronizers and edge-detect history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= {SYNC_STAGES{SS_IDLE}};
            sck_d     <= 1'b0;
            ss_act_d  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss};
            sck_d     <= sck_s;
            ss_act_d  <= ss_act;
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            word_buf_q <= '0;
            cap_q      <= 1'b0;
            first_q    <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy       <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            bit_idx_q  <= bit_idx_n;
            shift_q    <= shift_n;
            addr_q     <= addr_n;
            word_buf_q <= word_buf_n;
            cap_q      <= cap_n;
            first_q    <= first_n;
            miso_q     <= miso_n;
            oe_q       <= oe_n;
            mem_rd_q   <= mem_rd_n;
            mem_addr_q <= mem_addr_n;
            busy       <= busy_n;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q     <= fast_n;
`endif
        end
    end

    // Next-state and next-output logic; deselect overrides everything.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        bit_idx_n  = bit_idx_q;
        shift_n    = shift_q;
        addr_n     = addr_q;
        word_buf_n = word_buf_q;
        cap_n      = mem_rd_q;
        first_n    = first_q;
        miso_n     = miso_q;
        oe_n       = oe_q;
        mem_rd_n   = 1'b0;
        mem_addr_n = mem_addr_q;
`ifdef SPI_FLASH_FAST_READ_EN
        fast_n     = fast_q;
`endif

        if (!ss_act) begin
            state_n = ST_IDLE;
            miso_n  = 1'b0;
            oe_n    = 1'b0;
            cap_n   = 1'b0;
            first_n = 1'b0;
        end else begin
            if (cap_q) begin
                word_buf_n = bus.mem_rdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sel_edge) begin
                        state_n   = ST_CMD;
                        bit_cnt_n = '0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        shift_n = {shift_q[SHIFT_BITS-2:0], mosi_s};
                        if (bit_cnt_q == CNT_BITS'(7)) begin
                            bit_cnt_n = '0;
                            if (cmd_in == CMD_READ) begin
                                state_n = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                                fast_n  = 1'b0;
                            end else if (cmd_in == CMD_FAST_READ) begin
                                state_n = ST_ADDR;
                                fast_n  = 1'b1;
`endif
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        shift_n = {shift_q[SHIFT_BITS-2:0], mosi_s};
                        if (bit_cnt_q == CNT_BITS'(23)) begin
                            bit_cnt_n  = '0;
                            bit_idx_n  = '0;
                            addr_n     = addr_in;
                            mem_rd_n   = 1'b1;
                            mem_addr_n = addr_in[ADDR_BITS-1:2];
`ifdef SPI_FLASH_FAST_READ_EN
                            if (fast_q) state_n = ST_DUMMY; else
`endif
                            begin
                                state_n = ST_DATA;
                                oe_n    = 1'b1;
                                first_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    // Word is already buffered; first bit goes out with the last dummy rise.
                    if (rise) begin
                        if (bit_cnt_q == CNT_BITS'(7)) begin
                            bit_cnt_n = '0;
                            state_n   = ST_DATA;
                            oe_n      = 1'b1;
                            miso_n    = word_buf_q[{addr_q[1:0], ~bit_idx_q}];
                        end else begin
                            bit_cnt_n = bit_cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                ST_DATA: begin
                    // Initial word arrives after entry: present its first bit straight away.
                    if (cap_q && first_q) begin
                        miso_n  = bus.mem_rdata[{addr_q[1:0], ~bit_idx_q}];
                        first_n = 1'b0;
                    end
                    if (rise) begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_n = '0;
                            addr_n    = addr_inc;
                            if (addr_inc[1:0] == 2'b00) begin
                                mem_rd_n   = 1'b1;
                                mem_addr_n = addr_inc[ADDR_BITS-1:2];
                            end
                        end else begin
                            bit_idx_n = bit_idx_q + 3'd1;
                        end
                    end else if (fall) begin
                        miso_n = word_buf_q[{addr_q[1:0], ~bit_idx_q}];
                    end
                end
                ST_IGNORE: begin
                    miso_n = 1'b0;
                    oe_n   = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end
endmodule

// File: tb/tb_spi_flash_xip_slave.sv
// Directed bench for spi_flash_xip_slave: the bench acts as SPI master and
// backing memory; a byte-level flash model predicts data and word fetches.
module tb_spi_flash_xip_slave;
    localparam int unsigned ADDR_BITS   = 24;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   mode   = 0;       // 0: pins must be quiet, 1: oe must be high, 2: unchecked
    bit   chk_on = 1'b0;

    logic [ADDR_BITS-3:0] rd_log[$];
    logic [7:0]           got_q[$];

    always #5 clock = ~clock;

    spi_flash_xip_slave_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    spi_flash_xip_slave #(
        .ADDR_BITS(ADDR_BITS),
        .SYNC_STAGES(SYNC_STAGES),
        .SS_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    // Flash contents: a few fixed words, a generated pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [ADDR_BITS-3:0] w);
        case (w)
            22'd0:        return 32'hDDCCBBAA;
            22'd1:        return 32'h44332211;
            22'd2:        return 32'h88776655;
            22'h3FFFFF:   return 32'hF1E2D3C4;
            default:      return {8'hA5 ^ w[7:0], w[7:0], 8'h3C, w[15:8]};
        endcase
    endfunction

    // Byte seen at flash byte address a (little-endian lanes within a word).
    function automatic logic [7:0] exp_byte(input logic [23:0] a);
        logic [31:0] wd;
        wd = mem_word(a[23:2]);
        return wd[8*a[1:0] +: 8];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory: data valid the cycle after the strobe; log every fetch.
    always @(posedge clock) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem_word(bus.mem_addr);
            rd_log.push_back(bus.mem_addr);
        end
    end

    // Per-cycle pin check against the expected phase of the frame.
    always @(negedge clock) begin
        if (chk_on && reset) begin
            if (mode == 0)
                chk(!bus.spi_miso_oe && !bus.spi_miso, "pins_quiet",
                    {30'd0, bus.spi_miso_oe, bus.spi_miso}, 32'd0);
            else if (mode == 1)
                chk(bus.spi_miso_oe == 1'b1, "oe_in_data", {31'd0, bus.spi_miso_oe}, 32'd1);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bit(input logic b, output logic s);
        bus.spi_mosi = b;
        wait_clk(HALF);
        s = bus.spi_miso;
        bus.spi_sck = 1'b1;
        wait_clk(HALF);
        bus.spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], s);
    endtask

    task automatic do_select();
        bus.spi_ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic deselect_check();
        mode = 2;
        bus.spi_ss = 1'b1;
        wait_clk(SYNC_STAGES + 1);
        chk(busy == 1'b0, "busy_after_deselect", {31'd0, busy}, 32'd0);
        mode = 0;
        wait_clk(4);
    endtask

    // Full read frame; data bytes and word fetches checked against the model.
    task automatic read_frame(input logic [7:0] cmd, input logic [23:0] a,
                              input int nbytes, input int ndummy);
        logic                 s;
        logic [7:0]           b;
        logic [23:0]          ba;
        logic [ADDR_BITS-3:0] exp_rd[$];
        rd_log.delete();
        got_q.delete();
        mode = 0;
        do_select();
        send_byte(cmd);
        for (int i = 23; i >= 0; i--) begin
            if (i == 0 && ndummy == 0) mode = 2;
            spi_bit(a[i], s);
        end
        for (int d = 0; d < ndummy; d++) begin
            if (d == ndummy - 1) mode = 2;
            spi_bit(1'b0, s);
        end
        mode = 1;
        for (int k = 0; k < nbytes; k++) begin
            b = '0;
            for (int j = 7; j >= 0; j--) begin
                spi_bit(1'b0, s);
                b[j] = s;
            end
            got_q.push_back(b);
            ba = a + 24'(k);
            chk(b == exp_byte(ba), "data_byte", {24'd0, b}, {24'd0, exp_byte(ba)});
        end
        deselect_check();
        exp_rd.push_back(a[23:2]);
        for (int k = 1; k <= nbytes; k++) begin
            ba = a + 24'(k);
            if (ba[1:0] == 2'b00) exp_rd.push_back(ba[23:2]);
        end
        chk(rd_log.size() == exp_rd.size(), "mem_rd_count", rd_log.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++)
            chk(rd_log[k] == exp_rd[k], "mem_rd_addr", {10'd0, rd_log[k]}, {10'd0, exp_rd[k]});
    endtask

    // Frame whose command must be ignored: pins stay quiet, no fetch.
    task automatic ignored_frame(input logic [7:0] cmd);
        logic s;
        rd_log.delete();
        mode = 0;
        do_select();
        send_byte(cmd);
        for (int i = 0; i < 40; i++) spi_bit(i[0], s);
        deselect_check();
        chk(rd_log.size() == 0, "ignored_no_mem_rd", rd_log.size(), 0);
    endtask

    initial begin
        logic s;
        bus.spi_sck  = 1'b0;
        bus.spi_ss   = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_clk(3);
        chk({bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, busy} == 4'b0, "reset_outputs",
            {28'd0, bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, busy}, 32'd0);
        chk(bus.mem_addr == '0, "reset_mem_addr", {10'd0, bus.mem_addr}, 32'd0);
        reset = 1'b1;
        wait_clk(3);
        chk(busy == 1'b0, "idle_after_reset", {31'd0, busy}, 32'd0);
        chk_on = 1'b1;

        // Word 0, four bytes in lane order.
        read_frame(8'h03, 24'h000000, 4, 0);
        chk(got_q[0] == 8'hAA, "t1_byte0", {24'd0, got_q[0]}, 32'hAA);
        chk(got_q[1] == 8'hBB, "t1_byte1", {24'd0, got_q[1]}, 32'hBB);
        chk(got_q[2] == 8'hCC, "t1_byte2", {24'd0, got_q[2]}, 32'hCC);
        chk(got_q[3] == 8'hDD, "t1_byte3", {24'd0, got_q[3]}, 32'hDD);
        chk(rd_log[0] == 22'd0, "t1_first_fetch", {10'd0, rd_log[0]}, 32'd0);

        // Unaligned start crossing into word 2.
        read_frame(8'h03, 24'h000006, 3, 0);
        chk(got_q[0] == 8'h33, "t2_byte0", {24'd0, got_q[0]}, 32'h33);
        chk(got_q[1] == 8'h44, "t2_byte1", {24'd0, got_q[1]}, 32'h44);
        chk(got_q[2] == 8'h55, "t2_byte2", {24'd0, got_q[2]}, 32'h55);
        chk(rd_log.size() == 2 && rd_log[0] == 22'd1 && rd_log[1] == 22'd2, "t2_fetches",
            rd_log.size(), 2);

        // Top-of-space wrap.
        read_frame(8'h03, 24'hFFFFFF, 2, 0);
        chk(got_q[0] == 8'hF1, "wrap_byte0", {24'd0, got_q[0]}, 32'hF1);
        chk(got_q[1] == 8'hAA, "wrap_byte1", {24'd0, got_q[1]}, 32'hAA);
        chk(rd_log.size() == 2 && rd_log[0] == 22'h3FFFFF && rd_log[1] == 22'd0, "wrap_fetches",
            rd_log.size(), 2);

        // Unknown command.
        ignored_frame(8'h9F);

        // Abort after 12 address bits, then a clean read.
        rd_log.delete();
        mode = 0;
        do_select();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, s);
        deselect_check();
        chk(rd_log.size() == 0, "abort_no_mem_rd", rd_log.size(), 0);
        read_frame(8'h03, 24'h000004, 4, 0);
        chk(got_q[0] == 8'h11, "abort_byte0", {24'd0, got_q[0]}, 32'h11);
        chk(got_q[3] == 8'h44, "abort_byte3", {24'd0, got_q[3]}, 32'h44);

        // Fast read (or its rejection when the option is off).
`ifdef SPI_FLASH_FAST_READ_EN
        read_frame(8'h0B, 24'h000000, 4, 8);
        chk(got_q[0] == 8'hAA, "fast_byte0", {24'd0, got_q[0]}, 32'hAA);
        chk(got_q[3] == 8'hDD, "fast_byte3", {24'd0, got_q[3]}, 32'hDD);
`else
        ignored_frame(8'h0B);
`endif

        // Reset asserted in the middle of a data byte.
        mode = 0;
        do_select();
        send_byte(8'h03);
        for (int i = 23; i >= 0; i--) begin
            if (i == 0) mode = 2;
            spi_bit(i == 4, s);
        end
        mode = 1;
        for (int i = 0; i < 12; i++) spi_bit(1'b0, s);
        mode = 2;
        bus.spi_sck = 1'b1;
        wait_clk(3);
        @(posedge clock);
        #1;
        chk(bus.mem_addr == 22'd4, "pre_reset_mem_addr", {10'd0, bus.mem_addr}, 32'd4);
        reset = 1'b0;
        #1;
        chk({bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, busy} == 4'b0, "midreset_outputs",
            {28'd0, bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, busy}, 32'd0);
        chk(bus.mem_addr == '0, "midreset_mem_addr", {10'd0, bus.mem_addr}, 32'd0);
        bus.spi_sck = 1'b0;
        bus.spi_ss  = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        mode = 0;
        wait_clk(6);
        chk(busy == 1'b0, "idle_after_midreset", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Run-length guard.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
